// File: rtl/ctrl_pkg.sv
// Shared opcode/ALUOp constants and control bundle types
// for the MIPS pipeline control unit.
package ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_XOR   = 2'b11;

    typedef struct packed {
        logic       regdst;
        logic       alusrc;
        logic       memtoreg;
        logic       regwrite;
        logic       memread;
        logic       memwrite;
        logic [1:0] aluop;
        logic       jump;
        logic       branch;
        logic       branch_ne;
        logic       signzero;
    } ctrl_bundle_t;

    typedef struct packed {
        logic valid;
        logic regwrite;
        logic memtoreg;
    } wb_grp_t;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode-to-control table with illegal
// opcode flag.
module ctrl_decode
    import ctrl_pkg::*;
(
    input  logic [5:0]   opcode,
    output ctrl_bundle_t ctrl,
    output logic         illegal
);

    // {regdst,alusrc,memtoreg,regwrite,memread,memwrite},
    // aluop, {jump,branch,branch_ne,signzero}
    always_comb begin
        ctrl    = '0;
        illegal = 1'b0;
        unique case (1'b1)
            (opcode == OP_RTYPE):
                ctrl = {6'b100100, ALUOP_FUNCT, 4'b0000};
            (opcode == OP_LW):
                ctrl = {6'b011110, ALUOP_ADD, 4'b0000};
            (opcode == OP_SW):
                ctrl = {6'b010001, ALUOP_ADD, 4'b0000};
            (opcode == OP_BEQ):
                ctrl = {6'b000000, ALUOP_SUB, 4'b0100};
            (opcode == OP_BNE):
                ctrl = {6'b000000, ALUOP_SUB, 4'b0110};
            (opcode == OP_ADDI):
                ctrl = {6'b010100, ALUOP_ADD, 4'b0000};
            (opcode == OP_XORI):
                ctrl = {6'b010100, ALUOP_XOR, 4'b0001};
            (opcode == OP_J):
                ctrl = {6'b000000, ALUOP_ADD, 4'b1000};
            default:
                illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/ctrl_pipe.sv
// Main pipeline control: ID decode, per-stage control
// registers, illegal-op pulse and stall/flush counters.
module ctrl_pipe
    import ctrl_pkg::*;
#(
    parameter int MEM_STAGES = 2,
    parameter int ALUOP_W    = 2,
    parameter int CNT_W      = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               id_valid,
    input  logic [5:0]         opcode,
    input  logic               stall,
    input  logic               flush,
    output logic               id_jump,
    output logic               id_branch,
    output logic               id_branch_ne,
    output logic               id_signzero,
    output logic               ex_valid,
    output logic               ex_regdst,
    output logic               ex_alusrc,
    output logic [ALUOP_W-1:0] ex_aluop,
    output logic               mem_valid,
    output logic               mem_memread,
    output logic               mem_memwrite,
    output logic               wb_valid,
    output logic               wb_regwrite,
    output logic               wb_memtoreg,
    output logic               illegal_op,
    output logic [CNT_W-1:0]   stall_cnt,
    output logic [CNT_W-1:0]   flush_cnt
);

    ctrl_bundle_t       dec;
    logic               dec_ill;
    logic               id_ok;
    logic               load;
    logic [ALUOP_W-1:0] aluop_ext;

    logic    ex_memread;
    logic    ex_memwrite;
    wb_grp_t ex_wb;
    wb_grp_t mem_wb;
    wb_grp_t wb_q [MEM_STAGES];

    ctrl_decode u_dec (
        .opcode  (opcode),
        .ctrl    (dec),
        .illegal (dec_ill)
    );

    assign id_jump      = id_valid & dec.jump;
    assign id_branch    = id_valid & dec.branch;
    assign id_branch_ne = id_valid & dec.branch_ne;
    assign id_signzero  = id_valid & dec.signzero;

    assign load  = ~stall & ~flush;
    assign id_ok = id_valid & ~dec_ill;

    always_comb begin
        aluop_ext      = '0;
        aluop_ext[1:0] = dec.aluop;
    end

    // ID/EX: stall and flush both insert a bubble
    always_ff @(posedge clk) begin
        if (reset || !load) begin
            ex_valid    <= 1'b0;
            ex_regdst   <= 1'b0;
            ex_alusrc   <= 1'b0;
            ex_aluop    <= '0;
            ex_memread  <= 1'b0;
            ex_memwrite <= 1'b0;
            ex_wb       <= '0;
        end else begin
            ex_valid    <= id_ok;
            ex_regdst   <= dec.regdst & id_ok;
            ex_alusrc   <= dec.alusrc & id_ok;
            ex_aluop    <= aluop_ext & {ALUOP_W{id_ok}};
            ex_memread  <= dec.memread & id_ok;
            ex_memwrite <= dec.memwrite & id_ok;
            ex_wb.valid    <= id_ok;
            ex_wb.regwrite <= dec.regwrite & id_ok;
            ex_wb.memtoreg <= dec.memtoreg & id_ok;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            illegal_op <= 1'b0;
        end else begin
            illegal_op <= id_valid & dec_ill & load;
        end
    end

    // EX onward never stalls
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_valid    <= 1'b0;
            mem_memread  <= 1'b0;
            mem_memwrite <= 1'b0;
            mem_wb       <= '0;
        end else begin
            mem_valid    <= ex_valid;
            mem_memread  <= ex_memread;
            mem_memwrite <= ex_memwrite;
            mem_wb       <= ex_wb;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < MEM_STAGES; k++) begin
                wb_q[k] <= '0;
            end
        end else begin
            wb_q[0] <= mem_wb;
            for (int k = 1; k < MEM_STAGES; k++) begin
                wb_q[k] <= wb_q[k-1];
            end
        end
    end

    assign wb_valid    = wb_q[MEM_STAGES-1].valid;
    assign wb_regwrite = wb_q[MEM_STAGES-1].regwrite;
    assign wb_memtoreg = wb_q[MEM_STAGES-1].memtoreg;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else if (flush) begin
            if (flush_cnt != '1) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end else if (stall) begin
            if (stall_cnt != '1) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: doc/ctrl_pipe.md
Name: ctrl_pipe

Overview:
- Parametrised main control unit for the 6-stage MIPS pipeline: IF, ID, EX, MEM1..MEMn, WB.
- Decodes the ID-stage opcode into a control bundle.
- Carries each control group through its own pipeline registers to the consuming stage, under stall and flush.
- Adds beq/addi decode, illegal-opcode detection, and saturating stall/flush event counters.

Parameters:
- MEM_STAGES, 2, number of memory stages between EX and WB; range 1..4; default 2 gives the 6-stage pipe.
- ALUOP_W, 2, ALUOp width; codes are zero-extended when ALUOP_W > 2.
- CNT_W, 16, width of the saturating event counters.

Ports:
- clk  in  1  pipeline clock
- reset  in  1  synchronous, active-high reset
- id_valid  in  1  the ID stage holds a real instruction
- opcode  in  6  instr[31:26] of the ID-stage instruction
- stall  in  1  hazard stall: ID/EX register loads a bubble
- flush  in  1  kill the ID-stage instruction (taken branch/jump)
- id_jump  out  1  combinational: jump decoded in ID
- id_branch  out  1  combinational: beq or bne
- id_branch_ne  out  1  combinational: 1 = bne, 0 = beq
- id_signzero  out  1  combinational: 1 = zero-extend immediate, 0 = sign-extend
- ex_valid  out  1  EX stage holds a real instruction
- ex_regdst  out  1  destination select: 1 = rd, 0 = rt
- ex_alusrc  out  1  ALU B operand: 1 = immediate
- ex_aluop  out  ALUOP_W  ALU operation class
- mem_valid  out  1  MEM1 holds a real instruction
- mem_memread  out  1  MEM1 read enable
- mem_memwrite  out  1  MEM1 write enable
- wb_valid  out  1  WB holds a real instruction
- wb_regwrite  out  1  register-file write enable
- wb_memtoreg  out  1  write-back data: 1 = memory, 0 = ALU
- illegal_op  out  1  one-cycle pulse: unknown opcode left ID
- stall_cnt  out  CNT_W  saturating count of stall cycles
- flush_cnt  out  CNT_W  saturating count of flush cycles

Behaviour:
Decode table. Fields are RegDst ALUSrc MemtoReg RegWrite MemRead MemWrite ALUOp Jump Branch BranchNe SignZero.
- 000000 R: 1 0 0 1 0 0 10 0 0 0 0
- 100011 lw: 0 1 1 1 1 0 00 0 0 0 0
- 101011 sw: 0 1 0 0 0 1 00 0 0 0 0 (no don't-cares; all defined)
- 000100 beq: 0 0 0 0 0 0 01 0 1 0 0
- 000101 bne: 0 0 0 0 0 0 01 0 1 1 0
- 001000 addi: 0 1 0 1 0 0 00 0 0 0 0
- 001110 xori: 0 1 0 1 0 0 11 0 0 0 1
- 000010 j: 0 0 0 0 0 0 00 1 0 0 0
- any other opcode: all fields 0; illegal = 1.

ID-stage outputs:
- id_* are purely combinational from opcode.
- id_* are gated by id_valid: all 0 when id_valid = 0.

ID/EX register, priority reset > flush > stall > load:
- reset: every registered output and both counters = 0 on the next edge.
- flush or stall: load a bubble (all control bits 0, valid 0).
- load: valid = id_valid & ~illegal; control bits are the decoded values ANDed with that valid.

Downstream registers:
- EX/MEM1, MEM1..MEMn and MEMn/WB shift unconditionally every cycle; stall never freezes EX or later.
- Each stage register carries only the groups still needed downstream.

Latency, for an instruction in ID at cycle t and not stalled or flushed:
- ex_* valid at t+1
- mem_* valid at t+2
- wb_* valid at t+2+MEM_STAGES; t+4 at the default MEM_STAGES = 2.

illegal_op:
- Registered; asserts at t+1 for one cycle.
- Requires id_valid = 1, an unknown opcode, and no stall, flush or reset at t.

Counters:
- stall_cnt increments on each cycle with stall = 1 and flush = 0.
- flush_cnt increments on each cycle with flush = 1 (flush dominates when both are high).
- Both hold at all-ones (saturate); no wrap.

Reset mid-operation:
- Every in-flight bundle is cleared on the same edge.
- No write enable (mem_memwrite, wb_regwrite) may assert afterwards for any instruction that entered before the reset.

Decomposition:
- Shared package ctrl_pkg holds:
  - opcode constants: OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_XORI, OP_J
  - ALUOp constants: ALUOP_ADD = 00, ALUOP_SUB = 01, ALUOP_FUNCT = 10, ALUOP_XOR = 11
  - packed typedef ctrl_bundle_t
- One natural sub-module, ctrl_decode: the combinational opcode-to-bundle table plus the illegal flag.
- ctrl_pipe instantiates ctrl_decode and owns all sequential logic: stage registers, MEM shift chain, counters.

Test Plan:
1. Reset, then id_valid = 1, opcode = 100011 (lw) at cycle 1 -> cycle 2: ex_alusrc = 1, ex_aluop = 00; cycle 3: mem_memread = 1; cycle 5: wb_regwrite = 1 and wb_memtoreg = 1.
2. Back-to-back R, sw, xori in cycles 1-3 -> ex_regdst sequence 1,0,0 in cycles 2-4; mem_memwrite = 1 only in cycle 4; id_signzero = 1 only in cycle 3.
3. sw in ID with stall = 1 for 2 cycles -> ex_valid = 0 for those 2 cycles; sw reaches EX the cycle after stall drops; stall_cnt = 2.
4. bne in ID with flush = 1 and stall = 1 together -> id_branch = 1 and id_branch_ne = 1 that cycle; bubble in EX next cycle; flush_cnt = 1, stall_cnt = 0.
5. opcode = 111111 with id_valid = 1 -> illegal_op pulses for exactly one cycle at t+1; no write enable asserts in any later stage.
6. CNT_W = 4 build, stall held for 20 cycles -> stall_cnt stops at 15. Separately, assert reset while an addi is in MEM1 -> wb_regwrite stays 0.
